main_memory_responder: RTL

//  Memory-side responder for the unified cache's refill/write-back handshake.

---
 rtl/cache_mem_pkg.sv | 28 ++
 rtl/mem_array_sp.sv | 52 +++++
 rtl/main_memory_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
// Shared definitions for the unified cache and its main-memory responder.
// Holds the responder FSM state type, the request op type, the default
// geometry shared with the cache, and a helper for the latency counter width.
package cache_mem_pkg;

  localparam int DEF_MEM_WORDS  = 4096;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LATENCY    = 10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  typedef enum logic {
    OP_FLUSH = 1'b0,
    OP_FETCH = 1'b1
  } op_t;

  // Counter must hold LATENCY; never narrower than one bit.
  function automatic int cnt_width(input int latency);
    return (latency > 0) ? $clog2(latency + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous RAM backing the memory responder.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset (read register only)
//   i_we     write enable; writes to out-of-range addresses are dropped
//   i_re     read enable; out-of-range reads return zero
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data, held until the next enabled read
module mem_array_sp #(
  parameter int MEM_WORDS  = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Contents are never reset; the initializer only gives simulation a zeroed array.
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;

  // One extra bit so MEM_WORDS == 2**ADDR_WIDTH still compares correctly.
  assign w_in_range = ({1'b0, i_addr} < (ADDR_WIDTH + 1)'(MEM_WORDS));
  assign w_idx      = i_addr[IDX_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_we && w_in_range) begin
      r_mem[w_idx] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder for the unified cache refill/write-back handshake.
// Accepts a flush (write-back) or fetch (refill) request, waits LATENCY
// cycles, performs the array access, pulses the matching ack for one cycle,
// then ignores requests for one holdoff cycle while the cache drops its level.
// Ports:
//   clka       clock, rising edge
//   rsta_n     asynchronous active-low reset
//   flush      write-back request level (wins over fetch)
//   fetch      refill request level
//   addr       word address, sampled at acceptance
//   wdata      write-back data, sampled at acceptance
//   rdata      refill data, valid with fetch_ack, held until next fetch
//   flush_ack  one-cycle pulse, write committed
//   fetch_ack  one-cycle pulse, rdata valid
//   busy       high whenever the FSM is not idle
module main_memory_responder
  import cache_mem_pkg::*;
#(
  parameter int MEM_WORDS  = DEF_MEM_WORDS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  flush,
  input  logic                  fetch,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  flush_ack,
  output logic                  fetch_ack,
  output logic                  busy
);

  localparam int               CNT_W    = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

  state_t                r_state;
  state_t                w_next;
  op_t                   r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_we;
  logic                  w_re;

  assign w_accept = (r_state == S_IDLE) && (flush || fetch);
  assign w_done   = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_we     = w_done && (r_op == OP_FLUSH);
  assign w_re     = w_done && (r_op == OP_FETCH);

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_op    <= OP_FLUSH;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_op    <= flush ? OP_FLUSH : OP_FETCH;
      r_addr  <= addr;
      r_wdata <= wdata;
      r_cnt   <= CNT_LOAD;
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_next    = r_state;
    flush_ack = 1'b0;
    fetch_ack = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (flush || fetch) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        flush_ack = (r_op == OP_FLUSH);
        fetch_ack = (r_op == OP_FETCH);
        w_next    = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The RAM read register doubles as the rdata output: it only updates on a
  // fetch access, so rdata holds across flushes.
  mem_array_sp #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .i_clk  (clka),
    .i_rst_n(rsta_n),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (r_addr),
    .i_wdata(r_wdata),
    .o_rdata(rdata)
  );

endmodule
